dmem_responder: RTL and testbench

Memory-side responder for the CPU data-memory port: 128-byte, byte-addressed, big-endian storage behind a valid/ready request channel and a valid/ready response channel, with a configurable access latency. It replaces the zero-latency combinational data memory so the pipeline's MEM stage can be exercised against a slow memory. The block serves one request at a time through a small FSM.

---
 rtl/dmem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the CPU data-memory port. Holds DEPTH bytes of
// big-endian, byte-addressed storage behind a valid/ready request channel and
// a valid/ready response channel. One request is served at a time; after
// acceptance the block waits WAIT_CYCLES cycles, commits the access (write of
// the enabled bytes, or capture of the read word) and presents the response
// until the initiator takes it.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request (registered)
//   req_write  in   1   1 = write, 0 = read
//   req_addr   in   AW  byte address of the word's most significant byte
//   req_be     in   4   write byte enables, be[3] -> wdata[31:24]
//   req_wdata  in   32  write data
//   rsp_valid  out  1   response present (registered)
//   rsp_ready  in   1   initiator takes the response
//   rsp_rdata  out  32  read data; 0 for writes and errors (registered)
//   rsp_err    out  1   misaligned access when ALLOW_MISALIGNED = 0
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int    DEPTH            = 128,
  parameter int    WAIT_CYCLES      = 2,
  parameter bit    ALLOW_MISALIGNED = 1'b1,
  parameter string INIT_FILE        = "data_memory.dat"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [3:0]               req_be,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  // The 4-bit counter cannot hold more than 15, and wrap-around addressing
  // relies on DEPTH being a power of two.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be within 0..15");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, rsp_valid_q;
  logic [7:0]      mem_q [DEPTH];

  logic            commit_s;
  logic            c_write_s;
  logic [AW-1:0]   c_addr_s;
  logic [3:0]      c_be_s;
  logic [31:0]     c_wdata_s;
  logic            err_s;
  logic [AW-1:0]   idx_s [4];
  logic [31:0]     rd_word_s;

  // Commit operand selection. With WAIT_CYCLES = 0 the commit happens on the
  // acceptance edge itself, so the live request fields are used; otherwise the
  // latched copy is used.
  always_comb begin
    c_write_s = write_q;
    c_addr_s  = addr_q;
    c_be_s    = be_q;
    c_wdata_s = wdata_q;
    if (state_q == ST_IDLE) begin
      c_write_s = req_write;
      c_addr_s  = req_addr;
      c_be_s    = req_be;
      c_wdata_s = req_wdata;
    end else begin
      c_write_s = write_q;
    end
    err_s = (!ALLOW_MISALIGNED) && (c_addr_s[1:0] != 2'b00);
    for (int k = 0; k < 4; k++) begin
      idx_s[k] = c_addr_s + AW'(k);
    end
    rd_word_s = {mem_q[idx_s[0]], mem_q[idx_s[1]], mem_q[idx_s[2]], mem_q[idx_s[3]]};
  end

  // Next-state and response-capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = WAIT_LD;
          if (WAIT_LD != 4'd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (commit_s) begin
      if (err_s) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else if (c_write_s) begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end else begin
        rdata_d = rd_word_s;
        err_d   = 1'b0;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Control and response registers; req_ready/rsp_valid are decodes of the
  // next state so both outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
    end
  end

  // Byte-enabled storage write on the commit edge; suppressed while reset is
  // held so a dropped request never lands in storage.
  always_ff @(posedge clk) begin
    if (reset && commit_s && c_write_s && !err_s) begin
      for (int k = 0; k < 4; k++) begin
        if (c_be_s[3-k]) begin
          mem_q[idx_s[k]] <= c_wdata_s[31-8*k -: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Two instances: unit 0 has WAIT_CYCLES=2
// with misaligned access allowed, unit 1 has WAIT_CYCLES=0 with misaligned
// access flagged as an error.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid_s;
  logic [1:0]  req_ready_s;
  logic [1:0]  req_write_s;
  logic [6:0]  req_addr_s  [2];
  logic [3:0]  req_be_s    [2];
  logic [31:0] req_wdata_s [2];
  logic [1:0]  rsp_valid_s;
  logic [1:0]  rsp_ready_s;
  logic [31:0] rsp_rdata_s [2];
  logic [1:0]  rsp_err_s;

  int n_cmp;
  int n_err;

  dmem_responder #(
    .DEPTH(128), .WAIT_CYCLES(2), .ALLOW_MISALIGNED(1'b1), .INIT_FILE("")
  ) u_dut_w2 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
    .req_write(req_write_s[0]), .req_addr(req_addr_s[0]),
    .req_be(req_be_s[0]), .req_wdata(req_wdata_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
    .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0])
  );

  dmem_responder #(
    .DEPTH(128), .WAIT_CYCLES(0), .ALLOW_MISALIGNED(1'b0), .INIT_FILE("")
  ) u_dut_w0 (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
    .req_write(req_write_s[1]), .req_addr(req_addr_s[1]),
    .req_be(req_be_s[1]), .req_wdata(req_wdata_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
    .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction. edges = clock edges from acceptance to the first
  // edge at which rsp_valid is seen high. hold_n > 0 keeps rsp_ready low for
  // that many cycles and checks the response stays put meanwhile.
  task automatic do_txn(input int u, input logic wr, input logic [6:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int hold_n, input logic [31:0] hold_exp,
                        output logic [31:0] rd, output logic er, output int edges);
    int guard;
    rd = 32'd0; er = 1'b0; edges = 0;
    @(negedge clk);
    req_write_s[u] = wr;
    req_addr_s[u]  = addr;
    req_be_s[u]    = be;
    req_wdata_s[u] = wd;
    req_valid_s[u] = 1'b1;
    rsp_ready_s[u] = (hold_n == 0);
    guard = 0;
    while (!req_ready_s[u] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      req_valid_s[u] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid_s[u] = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!rsp_valid_s[u] && guard < 50) begin
      edges++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check_val("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    edges = edges + 1;
    rd = rsp_rdata_s[u];
    er = rsp_err_s[u];
    for (int h = 0; h < hold_n; h++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(rsp_valid_s[u]), 32'd1);
      check_val("hold_rdata", rsp_rdata_s[u], hold_exp);
      check_val("hold_req_ready", 32'(req_ready_s[u]), 32'd0);
    end
    rsp_ready_s[u] = 1'b1;
    @(posedge clk);
    #1 rsp_ready_s[u] = 1'b0;
  endtask

  // req_valid held high: measure negedges between consecutive req_ready
  // samples and from acceptance to the first rsp_valid sample.
  task automatic run_stream(input int u, input logic [6:0] addr, input int period_exp);
    int first_acc;
    int second_acc;
    int first_vld;
    int guard;
    first_acc = -1; second_acc = -1; first_vld = -1;
    @(negedge clk);
    req_write_s[u] = 1'b0;
    req_addr_s[u]  = addr;
    req_be_s[u]    = 4'h0;
    req_valid_s[u] = 1'b1;
    rsp_ready_s[u] = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (req_ready_s[u]) begin
        if (first_acc < 0) first_acc = n;
        else if (second_acc < 0) second_acc = n;
      end
      if (rsp_valid_s[u] && first_vld < 0 && first_acc >= 0) first_vld = n;
      @(negedge clk);
    end
    req_valid_s[u] = 1'b0;
    guard = 0;
    while ((!req_ready_s[u] || rsp_valid_s[u]) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rsp_ready_s[u] = 1'b0;
    check_val("stream_period", 32'(second_acc - first_acc), 32'(period_exp));
    check_val("stream_rsp_delay", 32'(first_vld - first_acc), 32'(period_exp - 1));
  endtask

  logic [31:0] rd;
  logic        er;
  int          edges;
  logic [7:0]  exp_b [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid_s = 2'b00;
    req_write_s = 2'b00;
    rsp_ready_s = 2'b00;
    for (int u = 0; u < 2; u++) begin
      req_addr_s[u]  = 7'd0;
      req_be_s[u]    = 4'd0;
      req_wdata_s[u] = 32'd0;
    end

    #12;
    check_val("rst_req_ready", 32'(req_ready_s[0]), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid_s[0]), 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata_s[0], 32'd0);
    check_val("rst_rsp_err", 32'(rsp_err_s[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned word write then read, WAIT_CYCLES=2.
    do_txn(0, 1'b1, 7'h10, 4'hF, 32'hDEADBEEF, 0, 32'd0, rd, er, edges);
    check_val("w2_wr_latency", 32'(edges), 32'd3);
    check_val("w2_wr_rdata", rd, 32'd0);
    check_val("w2_wr_err", 32'(er), 32'd0);
    do_txn(0, 1'b0, 7'h10, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("w2_rd_word", rd, 32'hDEADBEEF);
    check_val("w2_rd_latency", 32'(edges), 32'd3);
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    for (int k = 0; k < 4; k++) begin
      check_val("mem_bytes_10", 32'(u_dut_w2.mem_q[16 + k]), 32'(exp_b[k]));
    end

    // Byte enables.
    do_txn(0, 1'b1, 7'h20, 4'hF, 32'h11223344, 0, 32'd0, rd, er, edges);
    do_txn(0, 1'b1, 7'h20, 4'b0101, 32'hAABBCCDD, 0, 32'd0, rd, er, edges);
    do_txn(0, 1'b0, 7'h20, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("be_merge", rd, 32'h11BB33DD);

    // Wrap-around at the top of storage.
    do_txn(0, 1'b1, 7'h7E, 4'hF, 32'h01020304, 0, 32'd0, rd, er, edges);
    check_val("wrap_wr_err", 32'(er), 32'd0);
    do_txn(0, 1'b0, 7'h7E, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("wrap_rd", rd, 32'h01020304);
    check_val("wrap_mem_7e", 32'(u_dut_w2.mem_q[126]), 32'h01);
    check_val("wrap_mem_7f", 32'(u_dut_w2.mem_q[127]), 32'h02);
    check_val("wrap_mem_00", 32'(u_dut_w2.mem_q[0]), 32'h03);
    check_val("wrap_mem_01", 32'(u_dut_w2.mem_q[1]), 32'h04);

    // Misaligned errors, WAIT_CYCLES=0.
    do_txn(1, 1'b1, 7'h20, 4'hF, 32'h11223344, 0, 32'd0, rd, er, edges);
    check_val("w0_wr_latency", 32'(edges), 32'd1);
    check_val("w0_wr_err", 32'(er), 32'd0);
    do_txn(1, 1'b0, 7'h20, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("w0_rd_word", rd, 32'h11223344);
    do_txn(1, 1'b1, 7'h21, 4'hF, 32'hFFFFFFFF, 0, 32'd0, rd, er, edges);
    check_val("mis_err", 32'(er), 32'd1);
    check_val("mis_rdata", rd, 32'd0);
    check_val("mis_mem_21", 32'(u_dut_w0.mem_q[33]), 32'h22);
    do_txn(1, 1'b0, 7'h20, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("mis_rd_after", rd, 32'h11223344);
    check_val("mis_rd_after_err", 32'(er), 32'd0);

    // Backpressure on both units.
    do_txn(0, 1'b0, 7'h10, 4'h0, 32'd0, 5, 32'hDEADBEEF, rd, er, edges);
    check_val("bp_w2_rd", rd, 32'hDEADBEEF);
    do_txn(1, 1'b0, 7'h20, 4'h0, 32'd0, 5, 32'h11223344, rd, er, edges);
    check_val("bp_w0_rd", rd, 32'h11223344);

    // req_valid held high: next acceptance only after the handshake.
    run_stream(0, 7'h10, 4);
    run_stream(1, 7'h20, 2);

    // Reset during WAIT drops the pending write.
    do_txn(0, 1'b1, 7'h40, 4'hF, 32'h12345678, 0, 32'd0, rd, er, edges);
    do_txn(0, 1'b0, 7'h40, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("rst_pre_rd", rd, 32'h12345678);
    @(negedge clk);
    req_write_s[0] = 1'b1;
    req_addr_s[0]  = 7'h40;
    req_be_s[0]    = 4'hF;
    req_wdata_s[0] = 32'hCAFEF00D;
    req_valid_s[0] = 1'b1;
    @(posedge clk);
    #1 req_valid_s[0] = 1'b0;
    @(negedge clk);
    check_val("rst_mid_in_wait", 32'(req_ready_s[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_req_ready", 32'(req_ready_s[0]), 32'd1);
    check_val("rst_mid_rsp_valid", 32'(rsp_valid_s[0]), 32'd0);
    check_val("rst_mid_rsp_rdata", rsp_rdata_s[0], 32'd0);
    check_val("rst_mid_rsp_err", 32'(rsp_err_s[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(0, 1'b0, 7'h40, 4'h0, 32'd0, 0, 32'd0, rd, er, edges);
    check_val("rst_post_rd", rd, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
